// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage feeding the single-cycle core.
// Issues sequential word fetches to instruction memory under a credit limit,
// buffers returned words with their PCs in an in-order queue, and hands one
// {instr, instr_pc} pair per cycle to the core. A redirect flushes the queue
// and marks every in-flight response as stale so it is silently dropped.
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   imem_req/addr         : fetch request and word-aligned address
//   imem_gnt              : request accepted this cycle
//   imem_rvalid/rdata     : in-order response stream
//   redirect_valid/pc     : restart fetch at a new target
//   instr_valid/instr/pc  : head of queue presented to the core
//   instr_ready           : core consumes the head entry
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [63:0]   q_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;

   logic          grant;
   logic          resp;
   logic          push;
   logic          pop;
   logic [SW-1:0] credits_used;
   logic [31:0]   redirect_aligned;
   logic          unused_redirect_lsb;

   // Low address bits of the redirect target are ignored.
   assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Handshake decode; credits cover queued entries plus in-flight requests.
   always_comb begin
      credits_used = SW'(count) + SW'(outstanding);
      imem_req     = !reset && !redirect_valid && (credits_used < SW'(DEPTH));
      grant        = imem_req && imem_gnt;
      resp         = imem_rvalid && (outstanding != '0);
      push         = resp && (drop == '0);
      pop          = instr_valid && instr_ready;
   end

   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != '0);
   // Output is forced to zero while empty so idle/reset values are clean.
   assign {instr, instr_pc} = instr_valid ? q_mem[rd_ptr] : 64'd0;

   // Control state: PCs, pointers, occupancy, credit and drop counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc    <= redirect_aligned;
         resp_pc     <= redirect_aligned;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= outstanding - CW'(resp);
         drop        <= outstanding - CW'(resp);
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (push) begin
            wr_ptr  <= wr_ptr + PW'(1);
            resp_pc <= resp_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count       <= count + CW'(push) - CW'(pop);
         outstanding <= outstanding + CW'(grant) - CW'(resp);
         if (resp && (drop != '0)) begin
            drop <= drop - CW'(1);
         end
      end
   end

   // Queue storage; contents are only observed through count, so no reset.
   always_ff @(posedge clock) begin
      if (!reset && !redirect_valid && push) begin
         q_mem[wr_ptr] <= {imem_rdata, resp_pc};
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue. A memory model answers
// grants after a programmable latency with rdata = addr ^ KEY; the main
// process drives directed phases and pushes expected PCs into a queue, and
// a monitor pops and compares on every accepted instruction.
module tb_ifetch_queue;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   logic [31:0] exp_q[$];
   int          lat;
   int          cyc;
   int          xfer;
   int          checks;
   int          passes;
   int          g;
   int          vcnt;

   ifetch_queue #(
      .DEPTH   (4),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act === want) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, want);
   endtask

   task automatic push_seq(input logic [31:0] start);
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   // Instruction memory: in-order responses, lat cycles after grant.
   initial begin
      cyc         = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      forever begin
         @(negedge clock);
         cyc = cyc + 1;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ KEY;
            void'(pend.pop_front());
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
         end
         #2;
         if (reset) pend.delete();
         else if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
      end
   end

   // Monitor: every accepted instruction must be the next expected PC/word.
   initial begin
      forever begin
         @(negedge clock);
         #3;
         if (!reset && !redirect_valid && instr_valid && instr_ready) begin
            xfer++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL mon_extra: got pc %h expected no transfer", instr_pc);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("mon_pc", instr_pc, e);
               chk("mon_instr", instr, e ^ KEY);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; passes = 0; xfer = 0; g = 0; vcnt = 0;
      reset = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'd0; lat = 1;
      repeat (3) @(negedge clock);
      #2;
      chk("rst_req",   32'(imem_req), 0);
      chk("rst_addr",  imem_addr, 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc",    instr_pc, 0);

      // Phase A: streaming with 1-cycle memory, always ready.
      @(negedge clock);
      reset = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
      exp_q.delete(); push_seq(32'h0); xfer = 0;
      #2;
      chk("a_req0",   32'(imem_req), 1);
      chk("a_addr0",  imem_addr, 0);
      chk("a_valid0", 32'(instr_valid), 0);
      @(negedge clock); #2;
      chk("a_addr1",  imem_addr, 4);
      chk("a_valid1", 32'(instr_valid), 0);
      @(negedge clock); #2;
      chk("a_valid2", 32'(instr_valid), 1);
      chk("a_pc2",    instr_pc, 0);
      vcnt = 0;
      repeat (9) begin
         @(negedge clock); #2;
         if (instr_valid) vcnt++;
      end
      chk("a_thruput", 32'(vcnt), 9);

      // Phase B: core stalls; queue fills with 40,44,48,52.
      @(negedge clock);
      instr_ready = 1'b0; g = 0;
      #2;
      chk("a_xfer", 32'(xfer), 10);
      if (imem_req && imem_gnt) g++;
      repeat (9) begin
         @(negedge clock); #2;
         if (imem_req && imem_gnt) g++;
      end
      chk("b_grants", 32'(g), 2);
      chk("b_req",    32'(imem_req), 0);
      chk("b_valid",  32'(instr_valid), 1);
      chk("b_head",   instr_pc, 32'd40);
      chk("b_addr",   imem_addr, 32'd56);

      // Reset with a full queue.
      @(negedge clock);
      reset = 1'b1;
      #2;
      chk("r_req", 32'(imem_req), 0);
      @(negedge clock); #2;
      chk("r_valid", 32'(instr_valid), 0);
      chk("r_instr", instr, 0);
      chk("r_pc",    instr_pc, 0);
      chk("r_addr",  imem_addr, 0);

      // Phase C: fresh start with ready low, then release.
      @(negedge clock);
      reset = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b0;
      exp_q.delete(); push_seq(32'h0); xfer = 0; g = 0;
      #2;
      if (imem_req && imem_gnt) g++;
      repeat (9) begin
         @(negedge clock); #2;
         if (imem_req && imem_gnt) g++;
      end
      chk("c_grants", 32'(g), 4);
      chk("c_req",    32'(imem_req), 0);
      chk("c_valid",  32'(instr_valid), 1);
      chk("c_head",   instr_pc, 0);
      chk("c_addr",   imem_addr, 32'd16);
      @(negedge clock);
      instr_ready = 1'b1;
      #2;
      repeat (9) @(negedge clock);

      // Phase D: 3-cycle memory, two in flight, redirect to 0x100.
      @(negedge clock);
      chk("c_xfer", 32'(xfer), 10);
      reset = 1'b1; imem_gnt = 1'b0; lat = 3;
      @(negedge clock);
      reset = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
      exp_q.delete(); push_seq(32'h0); xfer = 0;
      #2;
      chk("d_addr0", imem_addr, 0);
      @(negedge clock);
      @(negedge clock);
      imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
      exp_q.delete(); push_seq(32'h100);
      #2;
      chk("d_req_redir", 32'(imem_req), 0);
      @(negedge clock);
      redirect_valid = 1'b0; imem_gnt = 1'b1;
      #2;
      chk("d_req_new",  32'(imem_req), 1);
      chk("d_addr_new", imem_addr, 32'h100);
      chk("d_valid3",   32'(instr_valid), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #2;
         chk("d_stale_gap", 32'(instr_valid), 0);
      end
      @(negedge clock); #2;
      chk("d_valid7", 32'(instr_valid), 1);
      chk("d_pc7",    instr_pc, 32'h100);

      // Phase E: 2-cycle memory, redirect coincides with response and pop.
      @(negedge clock);
      reset = 1'b1; imem_gnt = 1'b0; lat = 2;
      @(negedge clock);
      reset = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
      exp_q.delete(); push_seq(32'h0); xfer = 0;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      exp_q.delete(); push_seq(32'h200); xfer = 0;
      #2;
      chk("e_rvalid", 32'(imem_rvalid), 1);
      chk("e_popping", 32'(instr_valid), 1);
      @(negedge clock);
      redirect_valid = 1'b0;
      #2;
      chk("e_addr", imem_addr, 32'h200);
      chk("e_valid4", 32'(instr_valid), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock); #2;
         chk("e_gap", 32'(instr_valid), 0);
      end
      @(negedge clock); #2;
      chk("e_valid7", 32'(instr_valid), 1);
      chk("e_pc7",    instr_pc, 32'h200);
      repeat (5) @(negedge clock);

      // Phase F: misaligned redirect near the top of the address space.
      @(negedge clock);
      chk("e_xfer", 32'(xfer), 6);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      exp_q.delete(); push_seq(32'hFFFF_FFFC); xfer = 0;
      #2;
      chk("f_req_redir", 32'(imem_req), 0);
      @(negedge clock);
      redirect_valid = 1'b0;
      #2;
      chk("f_addr1", imem_addr, 32'hFFFF_FFFC);
      @(negedge clock); #2;
      chk("f_addr_wrap", imem_addr, 32'h0);
      repeat (8) @(negedge clock);
      @(negedge clock);
      chk("f_xfer", 32'(xfer), 7);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage directly upstream of the single-cycle RISC-V `core`. Generates sequential word fetch addresses to instruction memory over a request/grant/response handshake and buffers returned words with their PCs in an in-order queue. Presents one `{instr, instr_pc}` pair to the core per cycle under a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes the queue and discards stale in-flight responses.

## Interface
- `DEPTH`, 4: queue entries and maximum credits (queued + outstanding); power of two, ≥2
- `RESET_PC`, 32'h00000000: first fetch address after reset; bits [1:0] must be 0
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address (word aligned)
- `imem_gnt`  in  1  request accepted this cycle when `imem_req && imem_gnt`
- `imem_rvalid`  in  1  response valid; responses return in request order, earliest the cycle after grant
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- `instr_valid`  out  1  `instr`/`instr_pc` valid
- `instr`  out  32  instruction word to core
- `instr_pc`  out  32  address of `instr`
- `instr_ready`  in  1  core consumes the head entry when `instr_valid && instr_ready`

## Operation
- State: `fetch_pc`, `resp_pc` (PC of next expected response), queue (DEPTH × 64 bits, rd/wr pointers, count 0..DEPTH), `outstanding` (0..DEPTH), `drop` (0..DEPTH).
- Issue: `imem_req = !reset && !redirect_valid && (count + outstanding < DEPTH)`; `imem_addr = fetch_pc`. On grant `fetch_pc += 4` (mod 2^32), `outstanding += 1`. Address held stable while `imem_req && !imem_gnt`.
- Response: each `imem_rvalid` decrements `outstanding`. If `drop > 0`: discard, `drop -= 1`. Else push `{imem_rdata, resp_pc}`, `resp_pc += 4` (mod 2^32).
- Credit rule guarantees no push to a full queue; simultaneous push and pop at full or empty are legal and leave count unchanged. `imem_rvalid` with `outstanding == 0` is a protocol error; ignored.
- Pop: head advances on `instr_valid && instr_ready`.
- Redirect cycle (`redirect_valid = 1`): queue emptied (count 0, pointers 0), any pop/push that cycle discarded, `fetch_pc <= {redirect_pc[31:2], 2'b00}`, `resp_pc` likewise, `drop <= outstanding - imem_rvalid` (all remaining in-flight are stale), `outstanding <= outstanding - imem_rvalid`. No request issued that cycle. Back-to-back redirects: last wins; `drop` recomputed each time.
- Stale responses still consume credits until returned.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC, `instr_valid` 0, `instr` 0, `instr_pc` 0; count, outstanding, drop 0; `fetch_pc`/`resp_pc` RESET_PC. Reset mid-operation aborts all state identically; responses arriving after reset to pre-reset requests are not supported (imem reset together).
- First cycle after reset release: `imem_req` 1 at RESET_PC.
- Queue outputs registered: response at cycle N → `instr_valid` at N+1. Minimum grant→`instr_valid` latency 2 cycles with 1-cycle memory.
- Redirect at cycle R: `imem_req` 0 in R, 1 in R+1 at new PC (if credits allow); `instr_valid` 0 from R+1 until first new response +1.
- Steady-state throughput 1 instr/cycle with always-grant, 1-cycle memory, `instr_ready` 1.

## Test plan
- Reset, `imem_gnt`=1, memory returns `rdata = addr ^ 32'hA5A50000` one cycle after grant, `instr_ready`=1 → `instr_pc` 0,4,8,…, matching `instr`, one per cycle from cycle 2.
- `instr_ready`=0 for 10 cycles → exactly 4 grants, queue full, `imem_req` 0; release → pcs 0,4,8,12,16… in order, none lost or duplicated.
- 3-cycle memory latency, 2 requests outstanding, redirect to 0x100 → both stale responses dropped, next `instr_pc` 0x100, no stale word ever visible.
- Redirect in same cycle as `imem_rvalid` and a pop → that response and pop discarded, `drop` = outstanding−1, next `instr_pc` = redirect target.
- Redirect to 0xFFFFFFFE → fetch 0xFFFFFFFC then 0x00000000 (wrap), `instr_pc` sequence matches.
- Assert `reset` mid-stream with full queue → next cycle all outputs at reset values; fetch restarts at RESET_PC.
